// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: RV32I load/store funct3
// encodings and the request FSM state type.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    ACCESS,
    RESP
  } dmem_state_t;

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane steering for RV32I loads/stores: store byte enables
// and replicated write data, load extraction/extension, and error detection.
module mem_lane_align
  import dmem_pkg::*;
(
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  byte_en,
  output logic [31:0] wdata_lane,
  output logic [31:0] rdata_ext,
  output logic        err
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  // Unsigned funct3 codes are only legal for loads.
  always_comb begin
    err = 1'b0;
    case (funct3)
      F3_B:    err = 1'b0;
      F3_H:    err = addr_lo[0];
      F3_W:    err = (addr_lo != 2'b00);
      F3_BU:   err = we;
      F3_HU:   err = we | addr_lo[0];
      default: err = 1'b1;
    endcase
  end

  always_comb begin
    byte_en    = 4'b0000;
    wdata_lane = 32'h0;
    if (we && !err) begin
      case (funct3)
        F3_B: begin
          byte_en    = 4'b0001 << addr_lo;
          wdata_lane = {4{wdata[7:0]}};
        end
        F3_H: begin
          byte_en    = addr_lo[1] ? 4'b1100 : 4'b0011;
          wdata_lane = {2{wdata[15:0]}};
        end
        F3_W: begin
          byte_en    = 4'b1111;
          wdata_lane = wdata;
        end
        default: begin
          byte_en    = 4'b0000;
          wdata_lane = 32'h0;
        end
      endcase
    end
  end

  always_comb begin
    sel_byte = rword[7:0];
    case (addr_lo)
      2'd0:    sel_byte = rword[7:0];
      2'd1:    sel_byte = rword[15:8];
      2'd2:    sel_byte = rword[23:16];
      default: sel_byte = rword[31:24];
    endcase
    sel_half = addr_lo[1] ? rword[31:16] : rword[15:0];
  end

  // Stores and faulting accesses return zero data.
  always_comb begin
    rdata_ext = 32'h0;
    if (!we && !err) begin
      case (funct3)
        F3_B:    rdata_ext = {{24{sel_byte[7]}}, sel_byte};
        F3_H:    rdata_ext = {{16{sel_half[15]}}, sel_half};
        F3_W:    rdata_ext = rword;
        F3_BU:   rdata_ext = {24'h0, sel_byte};
        F3_HU:   rdata_ext = {16'h0, sel_half};
        default: rdata_ext = 32'h0;
      endcase
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// Memory-side responder for the RV32I load/store port: one request at a time,
// configurable wait states, response held until the core accepts it.
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int         DEPTH     = 1 << ADDR_WIDTH;
  localparam logic [3:0] WAIT_LAST = WAIT_STATES[3:0];

  dmem_state_t state, next_state;

  logic [3:0]            wait_cnt;
  logic                  lat_we;
  logic [2:0]            lat_funct3;
  logic [ADDR_WIDTH+1:0] lat_addr;
  logic [31:0]           lat_wdata;

  // Contents survive reset; they start at zero only at power-up.
  logic [31:0] mem [DEPTH] = '{default: '0};

  logic [ADDR_WIDTH-1:0] word_idx;
  logic [31:0]           rword;
  logic [3:0]            byte_en;
  logic [31:0]           wdata_lane;
  logic [31:0]           rdata_ext;
  logic                  align_err;
  logic                  accept;
  logic                  unused_addr_hi;

  assign accept         = (state == IDLE) && req_valid;
  assign req_ready      = (state == IDLE);
  assign rsp_valid      = (state == RESP);
  assign word_idx       = lat_addr[ADDR_WIDTH+1:2];
  assign rword          = mem[word_idx];
  assign unused_addr_hi = ^req_addr[31:ADDR_WIDTH+2];

  mem_lane_align u_align (
    .we         (lat_we),
    .funct3     (lat_funct3),
    .addr_lo    (lat_addr[1:0]),
    .wdata      (lat_wdata),
    .rword      (rword),
    .byte_en    (byte_en),
    .wdata_lane (wdata_lane),
    .rdata_ext  (rdata_ext),
    .err        (align_err)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (req_valid) next_state = (WAIT_STATES > 0) ? BUSY : ACCESS;
      BUSY:    if (wait_cnt == WAIT_LAST) next_state = ACCESS;
      ACCESS:  next_state = RESP;
      RESP:    if (rsp_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Counter sits at zero outside BUSY so each request sees a full wait.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt <= 4'd0;
    end else if (state == BUSY && next_state == BUSY) begin
      wait_cnt <= wait_cnt + 4'd1;
    end else begin
      wait_cnt <= 4'd0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lat_we     <= 1'b0;
      lat_funct3 <= 3'b000;
      lat_addr   <= '0;
      lat_wdata  <= 32'h0;
    end else if (accept) begin
      lat_we     <= req_we;
      lat_funct3 <= req_funct3;
      lat_addr   <= req_addr[ADDR_WIDTH+1:0];
      lat_wdata  <= req_wdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rsp_rdata <= 32'h0;
      rsp_err   <= 1'b0;
    end else if (state == ACCESS) begin
      rsp_rdata <= rdata_ext;
      rsp_err   <= align_err;
    end else if (state == RESP && rsp_ready) begin
      rsp_rdata <= 32'h0;
      rsp_err   <= 1'b0;
    end
  end

  // Byte enables are already zero for loads and faulting stores.
  always_ff @(posedge clk) begin
    if (state == ACCESS) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en[i]) mem[word_idx][8*i +: 8] <= wdata_lane[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed table-driven bench for data_mem_responder (WAIT_STATES=1), plus
// hand-written stall and mid-request reset sequences.
module tb_data_mem_responder;
  import dmem_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    string       name;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  data_mem_responder #(
    .ADDR_WIDTH  (10),
    .WAIT_STATES (1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic addVec(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_rdata,
                        input logic exp_err, input string name);
    vec_t v;
    v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata;
    v.exp_rdata = exp_rdata; v.exp_err = exp_err; v.name = name;
    vecs.push_back(v);
  endtask

  // Called at a negedge; returns the response and edges from accept to rsp_valid.
  task automatic applyStimulus(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                               input logic [31:0] wdata, output logic [31:0] rdata,
                               output logic err, output int lat);
    int guard = 0;
    while (!req_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 50) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    rdata = rsp_rdata;
    err   = rsp_err;
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          guard;

    addVec(1, F3_W,  32'h10,   32'hDEADBEEF, 32'h0,        0, "SW 10");
    addVec(0, F3_W,  32'h10,   32'h0,        32'hDEADBEEF, 0, "LW 10");
    addVec(1, F3_W,  32'h10,   32'h0,        32'h0,        0, "SW zero 10");
    addVec(1, F3_B,  32'h13,   32'h00000080, 32'h0,        0, "SB 13");
    addVec(0, F3_B,  32'h13,   32'h0,        32'hFFFFFF80, 0, "LB 13");
    addVec(0, F3_BU, 32'h13,   32'h0,        32'h00000080, 0, "LBU 13");
    addVec(0, F3_W,  32'h10,   32'h0,        32'h80000000, 0, "LW after SB");
    addVec(0, F3_B,  32'h12,   32'h0,        32'h0,        0, "LB 12");
    addVec(1, F3_H,  32'h22,   32'h0000ABCD, 32'h0,        0, "SH 22");
    addVec(0, F3_H,  32'h22,   32'h0,        32'hFFFFABCD, 0, "LH 22");
    addVec(0, F3_HU, 32'h22,   32'h0,        32'h0000ABCD, 0, "LHU 22");
    addVec(0, F3_H,  32'h21,   32'h0,        32'h0,        1, "LH 21 misaligned");
    addVec(0, F3_W,  32'h20,   32'h0,        32'hABCD0000, 0, "LW 20");
    addVec(1, F3_W,  32'h04,   32'h11223344, 32'h0,        0, "SW 04");
    addVec(1, F3_W,  32'h06,   32'h55667788, 32'h0,        1, "SW 06 misaligned");
    addVec(0, F3_W,  32'h04,   32'h0,        32'h11223344, 0, "LW 04 unchanged");
    addVec(0, 3'b011,32'h04,   32'h0,        32'h0,        1, "load f3 011");
    addVec(0, 3'b110,32'h04,   32'h0,        32'h0,        1, "load f3 110");
    addVec(1, F3_BU, 32'h00,   32'hFFFFFFFF, 32'h0,        1, "store f3 100");
    addVec(0, F3_W,  32'h00,   32'h0,        32'h0,        0, "LW 00 unchanged");
    addVec(1, F3_B,  32'h11,   32'hFFFFFF7F, 32'h0,        0, "SB 11");
    addVec(0, F3_W,  32'h10,   32'h0,        32'h80007F00, 0, "LW after SB 11");
    addVec(0, F3_H,  32'h12,   32'h0,        32'hFFFF8000, 0, "LH 12");
    addVec(0, F3_W,  32'h1010, 32'h0,        32'h80007F00, 0, "LW wrap 1010");

    repeat (2) @(negedge clk);
    checkOutput("reset req_ready", {31'h0, req_ready}, 32'h1);
    checkOutput("reset rsp_valid", {31'h0, rsp_valid}, 32'h0);
    checkOutput("reset rsp_rdata", rsp_rdata, 32'h0);
    checkOutput("reset rsp_err",   {31'h0, rsp_err}, 32'h0);
    reset = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata, rdata, err, lat);
      checkOutput({vecs[i].name, " rdata"}, rdata, vecs[i].exp_rdata);
      checkOutput({vecs[i].name, " err"}, {31'h0, err}, {31'h0, vecs[i].exp_err});
      checkOutput({vecs[i].name, " latency"}, lat, 32'd3);
    end

    // Response stall: a competing store is offered while the load response is held.
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = F3_W; req_addr = 32'h04;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    guard = 0;
    while (!rsp_valid && guard < 50) begin
      @(posedge clk);
      guard++;
      @(negedge clk);
    end
    checkOutput("stall latency", guard, 32'd3);
    checkOutput("stall rdata", rsp_rdata, 32'h11223344);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = F3_W; req_addr = 32'h04; req_wdata = 32'hBADBAD00;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      @(negedge clk);
      checkOutput("stall rsp_valid", {31'h0, rsp_valid}, 32'h1);
      checkOutput("stall held rdata", rsp_rdata, 32'h11223344);
      checkOutput("stall req_ready", {31'h0, req_ready}, 32'h0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("release rsp_valid", {31'h0, rsp_valid}, 32'h0);
    checkOutput("release req_ready", {31'h0, req_ready}, 32'h1);
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    applyStimulus(0, F3_W, 32'h04, 32'h0, rdata, err, lat);
    checkOutput("LW 04 after stall", rdata, 32'h11223344);

    // Mid-request reset: a store still waiting in BUSY must not reach the RAM.
    applyStimulus(0, F3_W, 32'h10, 32'h0, rdata, err, lat);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = F3_W; req_addr = 32'h30; req_wdata = 32'h12345678;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    checkOutput("busy req_ready", {31'h0, req_ready}, 32'h0);
    reset = 1'b0;
    #1;
    checkOutput("abort req_ready", {31'h0, req_ready}, 32'h1);
    checkOutput("abort rsp_valid", {31'h0, rsp_valid}, 32'h0);
    checkOutput("abort rsp_rdata", rsp_rdata, 32'h0);
    checkOutput("abort rsp_err",   {31'h0, rsp_err}, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    applyStimulus(0, F3_W, 32'h30, 32'h0, rdata, err, lat);
    checkOutput("LW 30 after abort", rdata, 32'h0);
    checkOutput("LW 30 latency", lat, 32'd3);
    applyStimulus(0, F3_W, 32'h10, 32'h0, rdata, err, lat);
    checkOutput("LW 10 survives reset", rdata, 32'h80007F00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
